key_event_sequencer: RTL and testbench
======================================

Name: key_event_sequencer

Overview:
- Sits between the PS/2 byte receiver and the scan-code-to-tone mapper.
- Parses the PS/2 set-2 make, break (F0) and extended (E0) byte sequences.
- Tracks currently held keys in a last-pressed-priority stack and drives the mapper's 8-bit scan-code input with the highest-priority held key, or 0x00 when no key is held.
- Resolves multi-key presses into a single monophonic note stream.

Parameters:
- DEPTH, 4, number of simultaneously held keys tracked (2..7).
- TIMEOUT_CYCLES, 50000000, idle cycles before forced release; used only with KEY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- rx_data  in  8  received PS/2 byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid on that cycle.
- key_code  out  8  scan code of the top-of-stack key; 0x00 when the stack is empty.
- key_active  out  1  high while the stack is non-empty.
- note_change  out  1  one-cycle pulse whenever key_code changes value.
- stack_count  out  3  number of held keys, 0..DEPTH.
- overflow  out  1  one-cycle pulse when a push evicts the oldest entry.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: key_code=0x00, key_active=0, note_change=0, stack_count=0, overflow=0. The stack is cleared and the parser is in IDLE.
- Only bytes with rx_valid=1 are processed; all other cycles are ignored.
- Parser FSM states and transitions:
  - IDLE: F0 -> BREAK; E0 -> EXT; any other code -> make event, stay in IDLE.
  - EXT: F0 -> EXT_BREAK; other code -> make event, go to IDLE.
  - BREAK / EXT_BREAK: any code -> break event, go to IDLE.
- An extended code is treated as the same byte value as its non-extended form (the E0 flag is dropped).
- Ignored bytes: 0xFA, 0xAA, 0xEE, 0xFE, 0x00, 0xFF. In any state these return the FSM to IDLE and have no stack effect.
- Make event, code C:
  - C=0x29 (space): clear the stack (all-notes-off).
  - C already in the stack (typematic repeat): no change, no note_change pulse.
  - Otherwise, if count < DEPTH: push C on top and increment count.
  - Otherwise (stack full): drop the bottom (oldest) entry, push C on top, count unchanged, pulse overflow.
- Break event, code C:
  - If C is in the stack: remove it, shift older entries up to close the gap, decrement count.
  - If C is absent: ignore it.
  - A break of 0x29 is ignored.
- Timing: the stack updates on the edge that samples the final byte (edge N). key_code, key_active and stack_count are registered from the stack state and are valid after edge N+1. note_change and overflow are high for exactly the cycle following edge N+1.
- note_change pulses only if the new key_code differs from the previous value. Removing a non-top entry produces no pulse.
- Back-to-back rx_valid on consecutive cycles must be handled: each byte is processed in order with no loss.
- A byte's rx_valid never coincides with another byte's, so there are no simultaneous events to arbitrate.
- Reset asserted mid-sequence (for example after F0) discards the partial sequence.

Optional Feature:
- Macro: KEY_TIMEOUT_EN.
- When defined:
  - A counter increments every cycle while stack_count>0 and rx_valid=0.
  - Any rx_valid resets the counter to 0.
  - When the counter reaches TIMEOUT_CYCLES-1, the stack is cleared (same effect as a 0x29 make, including note_change if key_code was non-zero) and the counter returns to 0.
  - The counter is held at 0 while the stack is empty.
- When undefined: no counter exists, and held keys persist until their break code or 0x29 arrives.

Test Plan:
- Reset, then send 1C -> after 2 cycles key_code=0x1C, key_active=1, stack_count=1, one note_change pulse.
- Send 1C,1B,F0,1B -> key_code goes 1C->1B->1C, two further note_change pulses, final stack_count=1. Then F0,1C -> key_code=0x00, key_active=0.
- Send 1C,1B,23 then F0,1B (non-top break) -> key_code stays 0x23, no note_change, stack_count=2. Repeated 23 (typematic) -> no change.
- DEPTH=4: send 1C,1B,23,2B,34 -> overflow pulses once, stack_count=4, key_code=0x34. Then F0,1C (evicted key) -> ignored, stack_count=4.
- Send E0,71 then E0,F0,71 -> key_code 0x71 then 0x00. Sequence F0,FA,1C -> FA aborts the break and 1C is treated as a make (key_code=0x1C). Send 29 -> stack cleared, key_code=0x00.
- With KEY_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 1C, then idle 100 cycles -> key_code=0x00, note_change pulse. Repeat with a 1B byte at cycle 60 -> no timeout until 100 cycles after that byte.

Source files
------------

// File: rtl/key_event_sequencer.sv
// ============================================================================
// Module   : key_event_sequencer
// Purpose  : PS/2 set-2 make/break/extended parser feeding a last-pressed-
//            priority key stack; drives a monophonic scan code to the mapper.
//            Optional idle auto-release is enabled by defining KEY_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_active,
    output logic       note_change,
    output logic [2:0] stack_count,
    output logic       overflow
);

    localparam logic [7:0] C_BREAK = 8'hF0;
    localparam logic [7:0] C_EXT   = 8'hE0;
    localparam logic [7:0] C_SPACE = 8'h29;
    localparam logic [2:0] C_DEPTH = 3'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EXT       = 2'd1,
        S_BREAK     = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_stack [DEPTH];
    logic [2:0] r_count;
    logic       r_ovf_pend;

    logic       w_ignore;
    logic       w_make;
    logic       w_break;
    logic       w_hit;
    logic [2:0] w_hit_idx;
    logic [7:0] w_top;
    logic       w_full;
    logic       w_timeout;

    assign w_top  = (r_count != 3'd0) ? r_stack[0] : 8'h00;
    assign w_full = (r_count == C_DEPTH);

    always_comb begin
        w_ignore = rx_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        w_make   = 1'b0;
        w_break  = 1'b0;
        if (rx_valid && !w_ignore) begin
            case (r_state)
                S_IDLE:  w_make  = (rx_data != C_BREAK) && (rx_data != C_EXT);
                S_EXT:   w_make  = (rx_data != C_BREAK);
                default: w_break = 1'b1;
            endcase
        end
    end

    // Codes are unique in the stack, so at most one live slot can match.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_hit && (3'(i) < r_count) && (r_stack[i] == rx_data)) begin
                w_hit     = 1'b1;
                w_hit_idx = 3'(i);
            end
        end
    end

`ifdef KEY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_idle_cnt;

    assign w_timeout = !rx_valid && (r_count != 3'd0) &&
                       (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (rx_valid || (r_count == 3'd0) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= 3'd0;
            r_ovf_pend  <= 1'b0;
            key_code    <= 8'h00;
            key_active  <= 1'b0;
            note_change <= 1'b0;
            stack_count <= 3'd0;
            overflow    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= 8'h00;
            end
        end else begin
            r_ovf_pend <= 1'b0;

            if (rx_valid) begin
                if (w_ignore) begin
                    r_state <= S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (rx_data == C_BREAK)    r_state <= S_BREAK;
                            else if (rx_data == C_EXT) r_state <= S_EXT;
                            else                       r_state <= S_IDLE;
                        end
                        S_EXT: begin
                            if (rx_data == C_BREAK) r_state <= S_EXT_BREAK;
                            else                    r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end

            // Slots at or beyond r_count are kept at zero so shifts stay clean.
            if (w_timeout || (w_make && (rx_data == C_SPACE))) begin
                r_count <= 3'd0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_stack[i] <= 8'h00;
                end
            end else if (w_make && !w_hit) begin
                for (int i = 1; i < DEPTH; i++) begin
                    r_stack[i] <= r_stack[i-1];
                end
                r_stack[0] <= rx_data;
                if (w_full) r_ovf_pend <= 1'b1;
                else        r_count    <= r_count + 3'd1;
            end else if (w_break && w_hit && (rx_data != C_SPACE)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (3'(i) >= w_hit_idx) r_stack[i] <= r_stack[i+1];
                end
                r_stack[DEPTH-1] <= 8'h00;
                r_count          <= r_count - 3'd1;
            end

            key_code    <= w_top;
            key_active  <= (r_count != 3'd0);
            stack_count <= r_count;
            note_change <= (w_top != key_code);
            overflow    <= r_ovf_pend;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_event_sequencer.sv
// ============================================================================
// Module   : tb_key_event_sequencer
// Purpose  : Directed and randomized checks of key_event_sequencer against a
//            queue-based model of the key stack and byte-sequence rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] key_code;
    logic       key_active;
    logic       note_change;
    logic [2:0] stack_count;
    logic       overflow;

    key_event_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .key_code    (key_code),
        .key_active  (key_active),
        .note_change (note_change),
        .stack_count (stack_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model: q[0] is the most recently pressed held key.
    logic [7:0] q[$];
    bit         m_brk;
    bit         m_ext;
    bit         m_ovf;
    logic [7:0] prev_top;

    logic [7:0] pool [12] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h71,
                              8'hF0, 8'hF0, 8'hE0, 8'h29, 8'hFA, 8'h1C};

    function automatic logic [7:0] m_top();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    task automatic model(input logic [7:0] b);
        int idx;
        m_ovf = 1'b0;
        idx   = -1;
        if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (m_brk) begin
            m_brk = 1'b0;
            m_ext = 1'b0;
            foreach (q[i]) if (q[i] == b) idx = i;
            if (idx >= 0 && b != 8'h29) q.delete(idx);
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0 && !m_ext) begin
            m_ext = 1'b1;
        end else begin
            m_ext = 1'b0;
            foreach (q[i]) if (q[i] == b) idx = i;
            if (b == 8'h29) begin
                q.delete();
            end else if (idx < 0) begin
                if (q.size() == DEPTH) begin
                    void'(q.pop_back());
                    m_ovf = 1'b1;
                end
                q.push_front(b);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after an active edge; the byte is sampled on the next edge.
    task automatic push_byte(input logic [7:0] b);
        prev_top = m_top();
        model(b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic settle_check();
        @(posedge clk); #1;
        chk("key_code",    key_code,              m_top());
        chk("key_active",  {7'd0, key_active},    {7'd0, q.size() != 0});
        chk("stack_count", {5'd0, stack_count},   8'(q.size()));
        chk("note_change", {7'd0, note_change},   {7'd0, m_top() != prev_top});
        chk("overflow",    {7'd0, overflow},      {7'd0, m_ovf});
    endtask

    task automatic send(input logic [7:0] b);
        push_byte(b);
        settle_check();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        m_brk    = 1'b0;
        m_ext    = 1'b0;
        m_ovf    = 1'b0;
        prev_top = 8'h00;
        idle(3);
        chk("rst_key_code",    key_code,            8'h00);
        chk("rst_key_active",  {7'd0, key_active},  8'h00);
        chk("rst_stack_count", {5'd0, stack_count}, 8'h00);
        chk("rst_note_change", {7'd0, note_change}, 8'h00);
        chk("rst_overflow",    {7'd0, overflow},    8'h00);
        rst_n = 1'b1;
        idle(1);

        // Single make, then the pulse must last only one cycle.
        send(8'h1C);
        chk("tp_first_code", key_code, 8'h1C);
        idle(1);
        chk("note_one_cycle", {7'd0, note_change}, 8'h00);

        // Top-of-stack break restores the older key.
        send(8'h1B); send(8'hF0); send(8'h1B);
        chk("tp_back_to_1C", key_code, 8'h1C);
        send(8'hF0); send(8'h1C);
        chk("tp_empty", key_code, 8'h00);

        // Non-top break and typematic repeat are silent.
        send(8'h1C); send(8'h1B); send(8'h23);
        send(8'hF0); send(8'h1B);
        send(8'h23);
        chk("tp_nontop", {5'd0, stack_count}, 8'd2);

        // Overflow evicts the oldest key; its later break is ignored.
        send(8'h29);
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
        send(8'hF0); send(8'h1C);
        chk("tp_evicted", {5'd0, stack_count}, 8'd4);

        // Extended make/break, aborted break, all-notes-off.
        send(8'h29);
        send(8'hE0); send(8'h71);
        send(8'hE0); send(8'hF0); send(8'h71);
        send(8'hF0); send(8'hFA); send(8'h1C);
        chk("tp_abort_make", key_code, 8'h1C);
        send(8'h29);

        // Back-to-back strobes on consecutive cycles.
        push_byte(8'h1B); push_byte(8'h23); push_byte(8'hF0); push_byte(8'h1B);
        settle_check();

        // Reset in the middle of a break sequence.
        push_byte(8'hF0);
        rst_n = 1'b0;
        #3;
        chk("midrst_key_code", key_code, 8'h00);
        chk("midrst_count",    {5'd0, stack_count}, 8'h00);
        q.delete();
        m_brk = 1'b0;
        m_ext = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send(8'h1C);

        // Randomized bursts of 1..3 back-to-back bytes.
        for (int n = 0; n < 300; n++) begin
            int len;
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) push_byte(pool[$urandom_range(0, 11)]);
            settle_check();
        end

`ifdef KEY_TIMEOUT_EN
        send(8'h29);
        send(8'h1C);
        idle(90);
        chk("tmo_still_held", {7'd0, key_active}, 8'h01);
        idle(20);
        chk("tmo_released", {7'd0, key_active}, 8'h00);
        chk("tmo_code", key_code, 8'h00);
        q.delete();
        send(8'h1C);
        idle(58);
        send(8'h1B);
        idle(90);
        chk("tmo_restart_held", {7'd0, key_active}, 8'h01);
        idle(20);
        chk("tmo_restart_released", {7'd0, key_active}, 8'h00);
        q.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
